eq_gain_spi: RTL and testbench



---
 rtl/eq_pkg.sv | 25 ++
 rtl/spi_sync.sv | 38 +++
 rtl/eq_gain_spi.sv | 158 +++++++++++++++
 tb/tb_eq_gain_spi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eq_pkg
// Description : Shared types and default constants for the EQ gain SPI port.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int              c_NUM_BANDS_DEF  = 4;
    localparam int              c_GAIN_W_DEF     = 8;
    localparam logic [7:0]      c_GAIN_RESET_DEF = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic int frame_w(input int num_bands, input int gain_w);
        return num_bands * gain_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_sync
// Description : Two-flop synchroniser with rise/fall detect for one pin.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_dly <= 1'b0;
        end else begin
            r_s1  <= din;
            r_s2  <= r_s1;
            r_dly <= r_s2;
        end
    end

    assign sync = r_s2;
    assign rise = r_s2 & ~r_dly;
    assign fall = ~r_s2 & r_dly;

endmodule
`default_nettype wire

// File: rtl/eq_gain_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eq_gain_spi
// Description : Oversampled SPI gain-frame receiver with shadow register and
//               sample-boundary atomic apply. Define EQ_GAIN_SPI_READBACK_EN
//               to shift the active gains out on sdo during each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_gain_spi
    import eq_pkg::*;
#(
    parameter int                NUM_BANDS  = c_NUM_BANDS_DEF,
    parameter int                GAIN_W     = c_GAIN_W_DEF,
    parameter logic [GAIN_W-1:0] GAIN_RESET = c_GAIN_RESET_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck,
    input  logic                          sdi,
    input  logic                          ce,
    input  logic                          sample_tick,
    output logic                          sdo,
    output logic [NUM_BANDS*GAIN_W-1:0]   gains,
    output logic                          pending,
    output logic                          frame_ok,
    output logic                          frame_err
);

    localparam int                 c_FRAME_W  = frame_w(NUM_BANDS, GAIN_W);
    localparam int                 c_CNT_W    = $clog2(c_FRAME_W + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_FRAME_W + 1);

    logic w_sck_s, w_sck_rise, w_sck_fall;
    logic w_ce_s, w_ce_rise, w_ce_fall;
    logic r_sdi_s1, r_sdi_s2;

    spi_sync u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .sync  (w_sck_s),
        .rise  (w_sck_rise),
        .fall  (w_sck_fall)
    );

    spi_sync u_ce_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ce),
        .sync  (w_ce_s),
        .rise  (w_ce_rise),
        .fall  (w_ce_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdi_s1 <= 1'b0;
            r_sdi_s2 <= 1'b0;
        end else begin
            r_sdi_s1 <= sdi;
            r_sdi_s2 <= r_sdi_s1;
        end
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [c_FRAME_W-1:0]   r_shift;
    logic [c_FRAME_W-1:0]   r_shadow;
    logic [c_FRAME_W-1:0]   r_gains;
    logic                   r_pending;
    logic                   w_start;
    logic                   w_shift_en;
    logic                   w_commit;
    logic                   w_reject;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ce_rise) w_state_nxt = SHIFT;
            SHIFT:   if (w_ce_fall) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gating sck on the synchronised ce keeps stray clocks outside a frame inert.
    always_comb begin
        w_start    = (r_state == IDLE)  && w_ce_rise;
        w_shift_en = (r_state == SHIFT) && w_sck_rise && w_ce_s;
        w_commit   = (r_state == CHECK) && (r_bit_cnt == c_CNT_FULL);
        w_reject   = (r_state == CHECK) && (r_bit_cnt != c_CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[c_FRAME_W-2:0], r_sdi_s2};
            if (r_bit_cnt != c_CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // A commit coinciding with a tick bypasses the shadow so no sample is missed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_gains   <= {NUM_BANDS{GAIN_RESET}};
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_shadow <= r_shift;
            if (sample_tick) begin
                r_gains   <= r_shift;
                r_pending <= 1'b0;
            end else begin
                r_pending <= 1'b1;
            end
        end else if (sample_tick && r_pending) begin
            r_gains   <= r_shadow;
            r_pending <= 1'b0;
        end
    end

`ifdef EQ_GAIN_SPI_READBACK_EN
    logic [c_FRAME_W-1:0] r_readback;

    always_ff @(posedge clk) begin
        if (reset)                                  r_readback <= '0;
        else if (w_start)                           r_readback <= r_gains;
        else if ((r_state == SHIFT) && w_sck_fall)  r_readback <= {r_readback[c_FRAME_W-2:0], 1'b0};
    end

    assign sdo = (r_state == SHIFT) && w_ce_s && r_readback[c_FRAME_W-1];
`else
    assign sdo = 1'b0;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, w_sck_s, w_sck_fall, w_ce_s};

    assign gains     = r_gains;
    assign pending   = r_pending;
    assign frame_ok  = w_commit;
    assign frame_err = w_reject;

endmodule
`default_nettype wire

// File: tb/tb_eq_gain_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eq_gain_spi
// Description : Scoreboard bench for eq_gain_spi with randomised SPI frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_gain_spi;

    localparam logic [31:0] c_RST_GAINS = {4{8'h80}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        ce = 1'b0;
    logic        tick_dir = 1'b0;
    logic        tick_rand = 1'b0;
    logic        sample_tick;
    logic        sdo;
    logic [31:0] gains;
    logic        pending;
    logic        frame_ok;
    logic        frame_err;

    assign sample_tick = tick_dir | tick_rand;

    eq_gain_spi dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .ce          (ce),
        .sample_tick (sample_tick),
        .sdo         (sdo),
        .gains       (gains),
        .pending     (pending),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_ok    = 0;
    int          n_err   = 0;
    logic [31:0] m_gains   = c_RST_GAINS;
    logic [31:0] m_shadow  = '0;
    bit          m_pending = 1'b0;
    bit          tick_rand_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_dir = 1'b1;
        wait_clk(1);
        tick_dir = 1'b0;
        wait_clk(1);
    endtask

    task automatic frame_begin(output logic [31:0] rb_exp);
`ifdef EQ_GAIN_SPI_READBACK_EN
        rb_exp = m_gains;
`else
        rb_exp = '0;
`endif
        ce = 1'b1;
        wait_clk(4);
    endtask

    task automatic shift_bits(input logic [63:0] data, input int nbits, output logic [63:0] rb);
        rb = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = data[i];
            wait_clk(6);
            rb  = {rb[62:0], sdo};
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits, input bit align);
        logic [31:0] rb_exp;
        logic [63:0] rb;
        frame_begin(rb_exp);
        shift_bits(data, nbits, rb);
        if (nbits == 32 && !tick_rand_en) check("readback", rb[31:0], rb_exp);
        wait_clk(3);
        ce = 1'b0;
        q.push_back('{ok: (nbits == 32), data: data[31:0]});
        // The CHECK cycle is the 4th clock after the ce pin falls.
        if (align) begin
            wait_clk(3);
            tick_dir = 1'b1;
            wait_clk(1);
            tick_dir = 1'b0;
            wait_clk(4);
        end else begin
            wait_clk(8);
        end
    endtask

    // Monitor: compare live outputs to the model, then advance the model.
    always @(negedge clk) begin
        exp_t e;
        bit   commit;
        check("gains", gains, m_gains);
        check("pending", {31'b0, pending}, {31'b0, m_pending});
        commit = 1'b0;
        if (frame_ok || frame_err) begin
            if (frame_ok) n_ok++;
            else          n_err++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: ok=%0b err=%0b with no frame outstanding at %0t",
                         frame_ok, frame_err, $time);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {30'b0, frame_ok, frame_err}, e.ok ? 32'd2 : 32'd1);
                commit = e.ok && frame_ok;
            end
        end
        if (reset) begin
            m_gains   = c_RST_GAINS;
            m_shadow  = '0;
            m_pending = 1'b0;
        end else if (commit && sample_tick) begin
            m_gains   = e.data;
            m_shadow  = e.data;
            m_pending = 1'b0;
        end else if (commit) begin
            m_shadow  = e.data;
            m_pending = 1'b1;
        end else if (sample_tick && m_pending) begin
            m_gains   = m_shadow;
            m_pending = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_rand = tick_rand_en && ($urandom_range(0, 15) == 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok0, err0;
        logic [63:0] rb;
        logic [31:0] rb_exp;

        wait_clk(2);
        reset = 1'b0;
        wait_clk(3);
        check("reset_gains", gains, 32'h80808080);
        check("reset_pending", {31'b0, pending}, 32'd0);
        check("reset_sdo", {31'b0, sdo}, 32'd0);

        // Valid frame, then apply on a tick.
        ok0 = n_ok;
        send_frame(64'h11223344, 32, 1'b0);
        check("valid_ok_count", 32'(n_ok - ok0), 32'd1);
        check("valid_pending", {31'b0, pending}, 32'd1);
        check("valid_gains_held", gains, 32'h80808080);
        pulse_tick();
        check("apply_gains", gains, 32'h11223344);
        check("apply_pending", {31'b0, pending}, 32'd0);

        // Short and long frames.
        ok0 = n_ok; err0 = n_err;
        send_frame(64'h7FFF_FFFF, 31, 1'b0);
        send_frame(64'h1_2345_6789, 33, 1'b0);
        check("len_err_count", 32'(n_err - err0), 32'd2);
        check("len_ok_count", 32'(n_ok - ok0), 32'd0);
        check("len_gains", gains, 32'h11223344);
        check("len_pending", {31'b0, pending}, 32'd0);

        // Commit and tick in the same cycle.
        send_frame(64'hDEADBEEF, 32, 1'b1);
        check("simul_gains", gains, 32'hDEADBEEF);
        check("simul_pending", {31'b0, pending}, 32'd0);

        // Last frame wins.
        send_frame(64'hAAAAAAAA, 32, 1'b0);
        send_frame(64'h55555555, 32, 1'b0);
        pulse_tick();
        check("overwrite_gains", gains, 32'h55555555);

        // sck activity with ce low.
        ok0 = n_ok; err0 = n_err;
        for (int i = 0; i < 5; i++) begin
            sdi = i[0];
            sck = 1'b1; wait_clk(4);
            sck = 1'b0; wait_clk(4);
        end
        wait_clk(6);
        check("idle_sck_pulses", 32'((n_ok - ok0) + (n_err - err0)), 32'd0);

        // Readback of a known gain set.
        send_frame(64'h12345678, 32, 1'b0);
        pulse_tick();
        check("rb_setup_gains", gains, 32'h12345678);
        send_frame(64'hC3C3_0F0F, 32, 1'b0);

        // Reset in the middle of a frame with a pending shadow.
        ok0 = n_ok; err0 = n_err;
        frame_begin(rb_exp);
        shift_bits(64'hFACE, 16, rb);
        reset = 1'b1;
        ce    = 1'b0;
        sdi   = 1'b0;
        sck   = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(10);
        check("midrst_gains", gains, 32'h80808080);
        check("midrst_pending", {31'b0, pending}, 32'd0);
        check("midrst_sdo", {31'b0, sdo}, 32'd0);
        check("midrst_pulses", 32'((n_ok - ok0) + (n_err - err0)), 32'd0);
        q.delete();
        pulse_tick();
        check("midrst_tick_gains", gains, 32'h80808080);

        // Randomised frames with random sample ticks.
        tick_rand_en = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int sel, len;
            logic [63:0] d;
            sel = $urandom_range(0, 3);
            len = (sel == 0) ? 31 : (sel == 1) ? 33 : 32;
            d   = {31'b0, 1'($urandom_range(0, 1)), 32'($urandom)};
            send_frame(d, len, 1'b0);
            wait_clk($urandom_range(0, 20));
        end
        tick_rand_en = 1'b0;
        wait_clk(2);
        pulse_tick();
        check("final_pending", {31'b0, pending}, 32'd0);

        wait_clk(20);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
